als_spi_reader: RTL
===================

Name: als_spi_reader

Overview:
- SPI master for the ambient-light sensor: periodically runs one 16-bit read frame over ncs/sck/sdo and extracts the 8-bit light level.
- Sits directly upstream of the RGB PWM stage inside lightpwm. Its data/data_valid output is the level the PWM duty logic consumes.
- Frame format: 4 leading zeros, 8 data bits (MSB first), 4 trailing zeros.

Parameters:
- CLK_DIV, 4: sck half-period in clk cycles (>=1).
- NCS_SETUP, 2: clk cycles from ncs falling to the first sck falling edge (>=1).
- SAMPLE_PERIOD, 1000: clk cycles between conversion ticks. Must be at least NCS_SETUP+32*CLK_DIV+4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- en  in  1  conversion enable, sampled at tick
- sdo  in  1  sensor serial data
- ncs  out  1  sensor chip select, active-low
- sck  out  1  serial clock, idle high
- data  out  8  last valid light level
- data_valid  out  1  one-cycle strobe when data updates
- frame_err  out  1  status of the last frame; 1 = leading or trailing nibble nonzero

Behaviour:
- Reset (rst_n=0 at a clk edge): ncs=1, sck=1, data=0, data_valid=0, frame_err=0. The period counter, bit counter and FSM are cleared.
- Reset mid-frame aborts the frame: ncs=1 and sck=1 at the next edge, no strobe is issued, and data is not updated.
- Period counter:
  - Free-running 0..SAMPLE_PERIOD-1, then wraps. Tick occurs when the count equals SAMPLE_PERIOD-1.
  - The first tick is SAMPLE_PERIOD-1 cycles after reset release.
  - A tick outside IDLE, or with en=0, is ignored. The counter never pauses.
- FSM states: IDLE, SETUP, SHIFT, DONE.
- IDLE:
  - ncs=1, sck=1.
  - Tick with en=1 moves to SETUP; ncs=0 from the next edge (time t_cs).
- SETUP:
  - Holds sck=1 for NCS_SETUP cycles.
  - First sck fall at t0 = t_cs+NCS_SETUP.
- SHIFT:
  - sck toggles every CLK_DIV cycles.
  - Fall k (k=1..16) at t0+(k-1)*2*CLK_DIV. Rise k at t0+(2k-1)*CLK_DIV.
  - Exactly 16 falls and 16 rises per frame.
- Sampling:
  - On the clk edge that drives sck 1->0, sdo is shifted into frame[0] of a 16-bit register, i.e. the value held during the last cycle of the high phase.
  - 16 samples give frame[15:0], MSB first.
- DONE:
  - Entered at t0+32*CLK_DIV, i.e. CLK_DIV cycles after rise 16.
  - On that edge: ncs=1, data=frame[11:4], frame_err=(frame[15:12]!=0)|(frame[3:0]!=0), data_valid=1 for exactly one cycle. Then return to IDLE.
- Total ncs-low time: NCS_SETUP+32*CLK_DIV cycles (130 with defaults).
- data is updated even when frame_err=1. frame_err is updated on every completed frame and holds between frames.
- en deasserted mid-frame: the frame completes normally; the next tick is ignored.
- sck never toggles while ncs=1. ncs never toggles while sck=0.

Test Plan:
- Sensor model: loads the word while ncs=1, drives word[15] on sdo, and shifts left one clk after it sees sck fall.
- Scenario 1: defaults, model word 0x0A50 -> ncs low exactly 130 cycles, 16 sck falls, data=0xA5, one data_valid pulse coincident with ncs rise, frame_err=0.
- Scenario 2: word 0x8FF0 -> data=0xFF, frame_err=1. Then 0x0001 -> data=0x00, frame_err=1. Then 0x0120 -> data=0x12, frame_err=0.
- Scenario 3: en=0 for 3 periods -> ncs/sck stay 1, no strobe.
  - en raised -> ncs falls 1 cycle after the next tick.
  - en dropped at sck fall 8 -> the frame completes and the following tick is skipped.
- Scenario 4: rst_n=0 for 1 cycle at sck fall 5 of word 0x0330 -> next edge ncs=1, sck=1, data=0, data_valid=0, frame_err=0. The next frame starts SAMPLE_PERIOD cycles after release.
- Scenario 5: 200 back-to-back periods of random model words (nibbles [15:12] and [3:0] zeroed) -> each data equals word[11:4], frame_err=0, strobes exactly SAMPLE_PERIOD apart.
- Scenario 6: CLK_DIV=1, NCS_SETUP=1, SAMPLE_PERIOD=40, word 0x07E0 -> ncs low 33 cycles, data=0x7E.

Source files
------------

// File: rtl/als_spi_reader.sv
// SPI master for the ambient-light sensor: one 16-bit read frame per sample period.
// The middle byte becomes the light level; any nonzero framing nibble raises frame_err.
module als_spi_reader #(
    parameter int CLK_DIV       = 4,
    parameter int NCS_SETUP     = 2,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       sdo,
    output logic       ncs,
    output logic       sck,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err
);

    localparam int PER_W   = $clog2(SAMPLE_PERIOD + 1);
    localparam int DIV_MAX = (CLK_DIV > NCS_SETUP) ? CLK_DIV : NCS_SETUP;
    localparam int DIV_W   = $clog2(DIV_MAX + 1);

    localparam logic [PER_W-1:0] PER_LAST   = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] SETUP_LAST = DIV_W'(NCS_SETUP - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bit_q, bit_d;
    logic [15:0]      frame_q, frame_d;
    logic             ncs_q, ncs_d;
    logic             sck_q, sck_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             tick;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        ncs_d   = ncs_q;
        sck_d   = sck_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = err_q;

        // The period counter free-runs regardless of the frame state.
        tick  = (per_q == PER_LAST);
        per_d = tick ? '0 : per_q + PER_W'(1);

        case (state_q)
            IDLE: begin
                ncs_d = 1'b1;
                sck_d = 1'b1;
                if (tick && en) begin
                    state_d = SETUP;
                    ncs_d   = 1'b0;
                    div_d   = '0;
                end
            end
            SETUP: begin
                if (div_q == SETUP_LAST) begin
                    state_d = SHIFT;
                    sck_d   = 1'b0;
                    frame_d = {frame_q[14:0], sdo};
                    bit_d   = 5'd1;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else if (bit_q == 5'd16) begin
                        // Last high phase finished: close the frame and publish it.
                        state_d = DONE;
                        ncs_d   = 1'b1;
                        data_d  = frame_q[11:4];
                        err_d   = (frame_q[15:12] != 4'd0) || (frame_q[3:0] != 4'd0);
                        valid_d = 1'b1;
                    end else begin
                        sck_d   = 1'b0;
                        frame_d = {frame_q[14:0], sdo};
                        bit_d   = bit_q + 5'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            per_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            ncs_q   <= 1'b1;
            sck_q   <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            ncs_q   <= ncs_d;
            sck_q   <= sck_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign ncs        = ncs_q;
    assign sck        = sck_q;
    assign data       = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;

endmodule
